// File: rtl/input_port_nbank_if.sv
// rtl/input_port_nbank_if.sv - BFT-side and user-side signal bundle for input_port_nbank.
interface input_port_nbank_if #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PAYLOAD_BITS  = 64
);
    logic [PACKET_BITS-1:0]   din_leaf_bft2interface;
    logic [NUM_LEAF_BITS-1:0] src_leaf;
    logic [NUM_PORT_BITS-1:0] src_port;
    logic                     freespace_update;
    logic [PACKET_BITS-1:0]   packet_from_input_port;
    logic [PAYLOAD_BITS-1:0]  dout2user;
    logic                     vld2user;
    logic                     ack_user2b_in;
    logic [NUM_ADDR_BITS:0]   occupancy;
    logic                     overrun_err;

    modport master (
        output din_leaf_bft2interface, src_leaf, src_port, ack_user2b_in,
        input  freespace_update, packet_from_input_port, dout2user, vld2user,
               occupancy, overrun_err
    );

    modport slave (
        input  din_leaf_bft2interface, src_leaf, src_port, ack_user2b_in,
        output freespace_update, packet_from_input_port, dout2user, vld2user,
               occupancy, overrun_err
    );
endinterface

// File: rtl/input_port_nbank.sv
// rtl/input_port_nbank.sv - BFT leaf input port: N-bank tagged reorder buffer,
// in-order drain into a FWFT output FIFO, and freespace credit return.
module input_port_nbank #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int PORT_No               = 2,
    parameter int NUM_BANKS             = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int OUT_FIFO_ASIZE        = 4
) (
    input logic clk,
    input logic reset,
    input_port_nbank_if.slave bus
);
    localparam int DEPTH  = 1 << NUM_ADDR_BITS;
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FDEPTH = 1 << OUT_FIFO_ASIZE;
    localparam int FC_W   = OUT_FIFO_ASIZE + 1;
    localparam int CNT_W  = NUM_ADDR_BITS + 1;
    localparam int FILL_W = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;

    logic                     w_in_vld;
    logic [NUM_PORT_BITS-1:0] w_in_port;
    logic [NUM_ADDR_BITS-1:0] w_in_addr;
    logic [PAYLOAD_BITS-1:0]  w_in_payload;
    logic                     w_accept;

    assign w_in_vld     = bus.din_leaf_bft2interface[PACKET_BITS-1];
    assign w_in_port    = bus.din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign w_in_addr    = bus.din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS];
    assign w_in_payload = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign w_accept     = w_in_vld && (w_in_port == NUM_PORT_BITS'(PORT_No));

    logic                     r_wr_en;
    logic [NUM_ADDR_BITS-1:0] r_wr_addr;
    logic [PAYLOAD_BITS-1:0]  r_wr_data;
    logic [DEPTH-1:0]         r_tag;
    logic [NUM_ADDR_BITS-1:0] r_rd_ptr;
    logic                     r_rd_pend;
    logic [PAYLOAD_BITS-1:0]  r_rd_data;
    logic [CNT_W-1:0]         r_occ;
    logic                     r_ovr;
    logic [PAYLOAD_BITS-1:0]  r_fifo [FDEPTH];
    logic [OUT_FIFO_ASIZE-1:0] r_f_wptr;
    logic [OUT_FIFO_ASIZE-1:0] r_f_rptr;
    logic [FC_W-1:0]          r_f_cnt;
    logic [CNT_W-1:0]         r_fs_cnt;
    logic                     r_fs_upd;

    logic                     w_wr_ok;
    logic                     w_rd_issue;
    logic                     w_f_vld;
    logic                     w_pop;
    logic [BANK_W-1:0]        w_wr_bank;
    logic [ROW_W-1:0]         w_wr_row;
    logic [BANK_W-1:0]        w_rd_bank;
    logic [ROW_W-1:0]         w_rd_row;
    logic [PAYLOAD_BITS-1:0]  w_bank_rd [NUM_BANKS];
    logic [PACKET_BITS-1:0]   w_credit_pkt;

    always_ff @(posedge clk) begin
        if (reset) r_wr_en <= 1'b0;
        else       r_wr_en <= w_accept;
        r_wr_addr <= w_in_addr;
        r_wr_data <= w_in_payload;
    end

    // A write onto a still-tagged entry is dropped, even if the reader frees it this cycle.
    assign w_wr_ok = r_wr_en && !r_tag[r_wr_addr];
    // Reserve a FIFO slot for the read still in the RAM pipeline so the FIFO cannot overflow.
    assign w_rd_issue = r_tag[r_rd_ptr] && ((r_f_cnt + FC_W'(r_rd_pend)) < FC_W'(FDEPTH));

    assign w_wr_bank = BANK_W'(r_wr_addr % NUM_BANKS);
    assign w_wr_row  = ROW_W'(r_wr_addr / NUM_BANKS);
    assign w_rd_bank = BANK_W'(r_rd_ptr % NUM_BANKS);
    assign w_rd_row  = ROW_W'(r_rd_ptr / NUM_BANKS);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [PAYLOAD_BITS-1:0] r_mem [ROWS];
        always_ff @(posedge clk) begin
            if (w_wr_ok && (w_wr_bank == BANK_W'(b))) r_mem[w_wr_row] <= r_wr_data;
        end
        assign w_bank_rd[b] = r_mem[w_rd_row];
    end

    always_ff @(posedge clk) begin
        r_rd_data <= w_bank_rd[w_rd_bank];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag     <= '0;
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_occ     <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_issue;
            if (w_rd_issue) begin
                r_tag[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            if (w_wr_ok) r_tag[r_wr_addr] <= 1'b1;
            if (r_wr_en && r_tag[r_wr_addr]) r_ovr <= 1'b1;
            r_occ <= r_occ + CNT_W'(w_wr_ok) - CNT_W'(w_rd_issue);
        end
    end

    assign w_f_vld = (r_f_cnt != '0);
    assign w_pop   = w_f_vld && bus.ack_user2b_in;

    always_ff @(posedge clk) begin
        if (r_rd_pend) r_fifo[r_f_wptr] <= r_rd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_wptr <= '0;
            r_f_rptr <= '0;
            r_f_cnt  <= '0;
        end else begin
            if (r_rd_pend) r_f_wptr <= r_f_wptr + 1'b1;
            if (w_pop)     r_f_rptr <= r_f_rptr + 1'b1;
            r_f_cnt <= r_f_cnt + FC_W'(r_rd_pend) - FC_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_cnt <= '0;
            r_fs_upd <= 1'b0;
        end else begin
            r_fs_upd <= 1'b0;
            if (w_pop) begin
                if (r_fs_cnt == CNT_W'(FREESPACE_UPDATE_SIZE - 1)) begin
                    r_fs_cnt <= '0;
                    r_fs_upd <= 1'b1;
                end else begin
                    r_fs_cnt <= r_fs_cnt + 1'b1;
                end
            end
        end
    end

    assign w_credit_pkt = {1'b1, bus.src_leaf, bus.src_port, {FILL_W{1'b0}},
                           PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};

    assign bus.freespace_update       = r_fs_upd;
    assign bus.packet_from_input_port = r_fs_upd ? w_credit_pkt : '0;
    assign bus.dout2user              = w_f_vld ? r_fifo[r_f_rptr] : '0;
    assign bus.vld2user               = w_f_vld;
    assign bus.occupancy              = r_occ;
    assign bus.overrun_err            = r_ovr;
endmodule

// File: tb/tb_input_port_nbank.sv
// tb/tb_input_port_nbank.sv - directed and randomized bench for input_port_nbank
// against an address-ordered scoreboard and a credit-count model.
module tb_input_port_nbank;
    localparam int PB  = 97;
    localparam int NL  = 6;
    localparam int NP  = 4;
    localparam int NA  = 7;
    localparam int PL  = 64;
    localparam int PN  = 2;
    localparam int NB  = 2;
    localparam int FUS = 4;
    localparam int FA  = 4;
    localparam int DEP = 1 << NA;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_port_nbank_if #(.PACKET_BITS(PB), .NUM_LEAF_BITS(NL), .NUM_PORT_BITS(NP),
                          .NUM_ADDR_BITS(NA), .PAYLOAD_BITS(PL)) bus ();

    input_port_nbank #(.PACKET_BITS(PB), .NUM_LEAF_BITS(NL), .NUM_PORT_BITS(NP),
                       .NUM_ADDR_BITS(NA), .PAYLOAD_BITS(PL), .PORT_No(PN),
                       .NUM_BANKS(NB), .FREESPACE_UPDATE_SIZE(FUS),
                       .OUT_FIFO_ASIZE(FA)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [PL-1:0] exp_mem [DEP];
    bit            pend [DEP];
    int            mdl_next;
    int            mdl_fs_cnt;
    int            seg_strobes;
    bit            exp_ovr;
    logic [PB-1:0] credit_pkt;

    function automatic int pend_count();
        int n = 0;
        for (int i = 0; i < DEP; i++) n += int'(pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) pend[i] = 1'b0;
        mdl_next = 0;
        mdl_fs_cnt = 0;
        seg_strobes = 0;
        exp_ovr = 1'b0;
    endtask

    task automatic tick();
        logic xfer;
        logic [PL-1:0] word;
        logic exp_stb;
        xfer = !reset && bus.vld2user && bus.ack_user2b_in;
        word = bus.dout2user;
        exp_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (xfer) begin
            checks++;
            assert (pend[mdl_next] === 1'b1 && word === exp_mem[mdl_next]) else begin
                errors++;
                $error("FAIL data addr=%0d observed=%h expected=%h pending=%0d",
                       mdl_next, word, exp_mem[mdl_next], pend[mdl_next]);
            end
            pend[mdl_next] = 1'b0;
            mdl_next = (mdl_next + 1) % DEP;
            mdl_fs_cnt++;
            if (mdl_fs_cnt == FUS) begin
                mdl_fs_cnt = 0;
                exp_stb = 1'b1;
                seg_strobes++;
            end
        end
        checks++;
        assert (bus.freespace_update === exp_stb &&
                bus.packet_from_input_port === (exp_stb ? credit_pkt : PB'(0))) else begin
            errors++;
            $error("FAIL credit observed=%0d/%h expected=%0d/%h", bus.freespace_update,
                   bus.packet_from_input_port, exp_stb, exp_stb ? credit_pkt : PB'(0));
        end
    endtask

    task automatic send(input int addr, input logic [PL-1:0] pl,
                        input logic [NP-1:0] port = NP'(PN), input bit v = 1'b1);
        logic [PB-1:0] d;
        d = '0;
        d[PB-1] = v;
        d[PB-2 -: NL] = NL'($urandom);
        d[PB-2-NL -: NP] = port;
        d[PL+NA-1:PL] = NA'(addr);
        d[PL-1:0] = pl;
        bus.din_leaf_bft2interface = d;
        if (v && port == NP'(PN)) begin
            if (pend[addr]) exp_ovr = 1'b1;
            else begin
                pend[addr] = 1'b1;
                exp_mem[addr] = pl;
            end
        end
        tick();
        bus.din_leaf_bft2interface = '0;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 600 && pend_count() > 0; i++) begin
            bus.ack_user2b_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
        end
        bus.ack_user2b_in = 1'b1;
        tick();
        tick();
        checks++;
        assert (pend_count() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", pend_count());
        end
        checks++;
        assert (bus.vld2user === 1'b0 && bus.occupancy === '0) else begin
            errors++;
            $error("FAIL drained_idle observed=%0d/%0d expected=0/0", bus.vld2user, bus.occupancy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        assert (bus.vld2user === 1'b0 && bus.dout2user === '0 && bus.freespace_update === 1'b0 &&
                bus.packet_from_input_port === '0 && bus.occupancy === '0 &&
                bus.overrun_err === 1'b0) else begin
            errors++;
            $error("FAIL %s observed=%0d/%h/%0d/%h/%0d/%0d expected=all zero", tag, bus.vld2user,
                   bus.dout2user, bus.freespace_update, bus.packet_from_input_port,
                   bus.occupancy, bus.overrun_err);
        end
    endtask

    initial begin
        int base;
        int c0;
        int first;
        int n;
        int tmp;
        int j;
        int perm [24];

        reset = 1'b1;
        bus.din_leaf_bft2interface = '0;
        bus.ack_user2b_in = 1'b0;
        bus.src_leaf = 6'h2A;
        bus.src_port = 4'h9;
        credit_pkt = '0;
        credit_pkt[PB-1] = 1'b1;
        credit_pkt[PB-2 -: NL] = 6'h2A;
        credit_pkt[PB-2-NL -: NP] = 4'h9;
        credit_pkt[PL-1:0] = PL'(FUS);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset_state");

        // in-order fill with first-output latency
        bus.ack_user2b_in = 1'b1;
        c0 = cyc;
        first = -1;
        for (int a = 0; a < 10; a++) begin
            send(a, PL'(64'h100 + a));
            if (bus.vld2user && first < 0) first = cyc - c0;
        end
        checks++;
        assert (first === 4) else begin
            errors++;
            $error("FAIL first_vld_latency observed=%0d expected=4", first);
        end
        drain(1'b0);

        // out-of-order arrival stalls until the head address lands
        base = mdl_next;
        send((base + 3) % DEP, {$urandom, $urandom});
        send((base + 1) % DEP, {$urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (bus.vld2user === 1'b0) else begin
                errors++;
                $error("FAIL ooo_stall observed=%0d expected=0", bus.vld2user);
            end
            tick();
        end
        send(base, {$urandom, $urandom});
        send((base + 2) % DEP, {$urandom, $urandom});
        drain(1'b0);

        // foreign port and invalid packets are ignored
        send(mdl_next, {$urandom, $urandom}, 4'd5, 1'b1);
        send(mdl_next, {$urandom, $urandom}, NP'(PN), 1'b0);
        send((mdl_next + 1) % DEP, {$urandom, $urandom}, 4'd15, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        assert (bus.occupancy === '0 && bus.vld2user === 1'b0) else begin
            errors++;
            $error("FAIL ignore_foreign observed=%0d/%0d expected=0/0", bus.occupancy, bus.vld2user);
        end

        // backpressure: FIFO fills to its depth, rest stays tagged
        bus.ack_user2b_in = 1'b0;
        base = mdl_next;
        for (int i = 0; i < 40; i++) send((base + i) % DEP, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) tick();
        checks++;
        assert (bus.occupancy === 8'd24 && bus.vld2user === 1'b1) else begin
            errors++;
            $error("FAIL backpressure observed=%0d/%0d expected=24/1", bus.occupancy, bus.vld2user);
        end
        drain(1'b0);

        // randomized permutations with random ack; total traffic wraps the address space
        for (int r = 0; r < 10; r++) begin
            base = mdl_next;
            n = $urandom_range(8, 24);
            for (int i = 0; i < n; i++) perm[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            for (int i = 0; i < n; i++) begin
                bus.ack_user2b_in = ($urandom_range(0, 3) != 0);
                send((base + perm[i]) % DEP, {$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) tick();
            end
            drain(1'b1);
        end
        checks++;
        assert (bus.overrun_err === 1'b0) else begin
            errors++;
            $error("FAIL no_overrun observed=%0d expected=0", bus.overrun_err);
        end

        // overrun: duplicate address while the reader is stalled
        bus.ack_user2b_in = 1'b1;
        base = mdl_next;
        send((base + 1) % DEP, 64'hAAAA_0000_0000_0001);
        send((base + 1) % DEP, 64'hBBBB_0000_0000_0002);
        tick();
        tick();
        checks++;
        assert (bus.overrun_err === exp_ovr && exp_ovr) else begin
            errors++;
            $error("FAIL overrun_set observed=%0d expected=1", bus.overrun_err);
        end
        send(base, 64'hCCCC_0000_0000_0003);
        drain(1'b0);
        checks++;
        assert (bus.overrun_err === 1'b1) else begin
            errors++;
            $error("FAIL overrun_sticky observed=%0d expected=1", bus.overrun_err);
        end

        // reset mid-stream, then fresh traffic from address 0 with credit counting
        send(mdl_next, {$urandom, $urandom});
        send((mdl_next + 1) % DEP, {$urandom, $urandom});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_mid_stream");
        model_reset();
        for (int a = 0; a < 9; a++) send(a, {$urandom, $urandom});
        drain(1'b0);
        checks++;
        assert (seg_strobes === 2) else begin
            errors++;
            $error("FAIL credit_strobes observed=%0d expected=2", seg_strobes);
        end
        checks++;
        assert (bus.overrun_err === 1'b0) else begin
            errors++;
            $error("FAIL overrun_cleared observed=%0d expected=0", bus.overrun_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
